alu_seq: RTL and testbench
==========================

# alu_seq

Sequencer sitting between the operand stack and the combinational `alu`. It accepts one arithmetic/logic opcode at a time from the decode stage, pops the required operands from the stack, and drives `alu`'s `operand_a`, `operand_b` and `op_select` for a fixed number of settle cycles. It then pushes `result_lo`, plus `result_hi` for wide ops, back onto the stack and pulses completion. Multicycle ops (DIV/REM) get a longer, parameterised execute window.

## Interface
- `EXEC_CYCLES`, 1, cycles `alu` inputs are held before sampling result (non-divide ops); ≥1
- `DIV_CYCLES`, 4, hold cycles for DIV/REM; ≥1
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `op_valid`  in  1  opcode request valid
- `op_ready`  out  1  sequencer idle, can accept
- `op_code`  in  4  ALU operation (package encoding)
- `op_wide`  in  1  push `result_hi` as second word
- `pop_req`  out  1  request one stack word
- `pop_valid`  in  1  `pop_data` valid; handshake = `pop_req && pop_valid`
- `pop_data`  in  32  popped word
- `push_valid`  out  1  `push_data` valid
- `push_ready`  in  1  stack accepts push
- `push_data`  out  32  word to push
- `alu_a`, `alu_b`  out  32  to `alu` `operand_a`/`operand_b`
- `alu_op`  out  4  to `alu` `op_select`
- `alu_lo`, `alu_hi`  in  32  from `alu` `result_lo`/`result_hi`
- `done`  out  1  one-cycle pulse, op retired
- `trap`  out  1  one-cycle pulse, divide-by-zero (macro only)

## Operation
- States: IDLE, POP_B, POP_A, EXEC, PUSH_LO, PUSH_HI, DONE.
- IDLE: `op_ready`=1. On `op_valid`, latch `op_code`/`op_wide`, then go to POP_B.
- Unary ops (INC, NEG) pop one word into B. A is forced to 0; POP_A is skipped.
- Binary ops: first pop → B (top of stack), second pop → A.
- POP_x: `pop_req`=1 until the handshake. Data is captured on the handshake cycle; stall indefinitely otherwise.
- EXEC: `alu_a`/`alu_b`/`alu_op` come from registers and are stable for the whole state. Counter loads N−1 (N = `DIV_CYCLES` for DIV/REM, else `EXEC_CYCLES`). On the last cycle, capture `alu_lo`/`alu_hi` into result registers.
- PUSH_LO: `push_valid`=1, `push_data`=lo, held until `push_ready`. Next state is PUSH_HI if wide, else DONE.
- PUSH_HI: same, pushing hi.
- DONE: `done`=1 for one cycle, then IDLE.
- Outside EXEC, `alu_*` keep their last value (no glitching to 0).

## Timing
- Reset (async assert, sync-free deassert): state=IDLE, `op_ready`=1, `pop_req`=0, `push_valid`=0, `done`=0, `trap`=0, `alu_a`/`alu_b`=0, `alu_op`=0, result regs 0.
- Binary, non-wide op, no stalls, accept at cycle 0:
  - cycle 1: pop B
  - cycle 2: pop A
  - cycles 3..2+N: EXEC
  - cycle 3+N: push
  - cycle 4+N: `done`
  - cycle 5+N: `op_ready`
- Each stall cycle on pop/push adds exactly one cycle.
- `op_valid` is ignored while not IDLE. No request queueing.
- Reset mid-operation aborts: no push, no `done`. Already-popped words are lost; the caller re-issues.

## Configuration
- `ALU_DIV_ZERO_TRAP_EN` defined:
  - DIV/REM with B==0 skips EXEC and all pushes.
  - Goes directly to DONE with `trap`=1 and `done`=1 in that cycle.
- Undefined: `trap` is tied 0, and DIV/REM by zero executes and pushes whatever `alu` returns.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum: INC=0000, ADD=0001, SUB=0010, MUL=0011, DIV=0100, REM=0101, AND=0110, OR=0111, XOR=1000, NEG=1001.
  - Function `is_unary(op)`.
  - Function `is_div(op)`.
  - Sequencer state enum.
- No sub-module. The single FSM plus a counter is sufficient; `alu` is instantiated by the parent.

## Test plan
- ADD, stack pops 0xFF then 0xFF, `push_ready`=1 → `alu_op`=0001 in EXEC, single push 0x000001FE, `done` at cycle 5 (N=1).
- DIV 0xFF/0xFF → EXEC lasts exactly 4 cycles, push 0x00000001, `done` at cycle 8.
- AND 0xFF,0xFF with `pop_valid` low 3 cycles before each pop → push 0x000000FF, `done` delayed by exactly 6 cycles. `op_valid` pulsed mid-op is ignored.
- MUL wide, A=0x00010000, B=0x00010000, `push_ready` low 2 cycles on hi → pushes 0x00000000 then 0x00000001, `push_data` stable while stalled.
- INC, single pop 0x7 → exactly one `pop_req` handshake, `alu_a`=0, `alu_b`=7.
- DIV B=0: with `ALU_DIV_ZERO_TRAP_EN`, `trap` and `done` pulse together and no push. Separately, `rst_n` low during EXEC → outputs return to reset values immediately, no push.

Source files
------------

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Brief    : Opcode encoding, sequencer states and opcode helpers for alu_seq |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        OP_INC = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_MUL = 4'b0011,
        OP_DIV = 4'b0100,
        OP_REM = 4'b0101,
        OP_AND = 4'b0110,
        OP_OR  = 4'b0111,
        OP_XOR = 4'b1000,
        OP_NEG = 4'b1001
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP_B   = 3'd1,
        ST_POP_A   = 3'd2,
        ST_EXEC    = 3'd3,
        ST_PUSH_LO = 3'd4,
        ST_PUSH_HI = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_INC) || (op == OP_NEG);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_seq                                                         |
// | Brief    : Pops operands, holds them on the alu for a settle window, pushes |
// |            the result(s). Optional ALU_DIV_ZERO_TRAP_EN enables div-by-0 trap.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int DIV_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic        op_wide,
    output logic        pop_req,
    input  logic        pop_valid,
    input  logic [31:0] pop_data,
    output logic        push_valid,
    input  logic        push_ready,
    output logic [31:0] push_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    output logic        done,
    output logic        trap
);

    localparam int CNT_W = 16;

    seq_state_t        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              wide_q, wide_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       lo_q, lo_d, hi_q, hi_d;
    logic [31:0]       push_data_q, push_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_ready_q, op_ready_d;
    logic              pop_req_q, pop_req_d;
    logic              push_valid_q, push_valid_d;
    logic              done_q, done_d;
`ifdef ALU_DIV_ZERO_TRAP_EN
    logic              trap_q, trap_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wide_d  = wide_q;
        a_d     = a_q;
        b_d     = b_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
`ifdef ALU_DIV_ZERO_TRAP_EN
        trap_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    op_d    = op_code;
                    wide_d  = op_wide;
                    state_d = ST_POP_B;
                end
            end
            ST_POP_B: begin
                if (pop_req_q && pop_valid) begin
                    b_d = pop_data;
                    if (is_unary(op_q)) begin
                        a_d     = 32'd0;
                        cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_POP_A;
                    end
                end
            end
            ST_POP_A: begin
                if (pop_req_q && pop_valid) begin
                    a_d     = pop_data;
                    cnt_d   = is_div(op_q) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(EXEC_CYCLES - 1);
                    state_d = ST_EXEC;
`ifdef ALU_DIV_ZERO_TRAP_EN
                    // Divisor already sits in B; retire straight away without touching the stack.
                    if (is_div(op_q) && (b_q == 32'd0)) begin
                        trap_d  = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    lo_d    = alu_lo;
                    hi_d    = alu_hi;
                    state_d = ST_PUSH_LO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PUSH_LO: begin
                if (push_valid_q && push_ready) begin
                    state_d = wide_q ? ST_PUSH_HI : ST_DONE;
                end
            end
            ST_PUSH_HI: begin
                if (push_valid_q && push_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered images of the next state.
        op_ready_d   = (state_d == ST_IDLE);
        pop_req_d    = (state_d == ST_POP_B) || (state_d == ST_POP_A);
        push_valid_d = (state_d == ST_PUSH_LO) || (state_d == ST_PUSH_HI);
        done_d       = (state_d == ST_DONE);
        push_data_d  = (state_d == ST_PUSH_HI) ? hi_d :
                       (state_d == ST_PUSH_LO) ? lo_d : push_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 4'd0;
            wide_q       <= 1'b0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            lo_q         <= 32'd0;
            hi_q         <= 32'd0;
            push_data_q  <= 32'd0;
            cnt_q        <= '0;
            op_ready_q   <= 1'b1;
            pop_req_q    <= 1'b0;
            push_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wide_q       <= wide_d;
            a_q          <= a_d;
            b_q          <= b_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            push_data_q  <= push_data_d;
            cnt_q        <= cnt_d;
            op_ready_q   <= op_ready_d;
            pop_req_q    <= pop_req_d;
            push_valid_q <= push_valid_d;
            done_q       <= done_d;
        end
    end

`ifdef ALU_DIV_ZERO_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign op_ready   = op_ready_q;
    assign pop_req    = pop_req_q;
    assign push_valid = push_valid_q;
    assign push_data  = push_data_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                      |
// | Brief    : Directed bench for alu_seq with a behavioural alu and stack.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_ready;
    logic [3:0]  op_code;
    logic        op_wide;
    logic        pop_req, pop_valid;
    logic [31:0] pop_data;
    logic        push_valid, push_ready;
    logic [31:0] push_data;
    logic [31:0] alu_a, alu_b, alu_lo, alu_hi;
    logic [3:0]  alu_op;
    logic        done, trap;

    int n_chk  = 0;
    int n_pass = 0;

    // per-operation observations
    int          n_pop, n_push, done_cyc, last_pop_cyc, first_push_cyc;
    logic [31:0] push0, push1, a_seen, b_seen;
    logic [3:0]  op_seen;
    logic        trap_seen, push_unstable, ready_after, popreq_after;

    always #5 clk = ~clk;

    alu_seq #(.EXEC_CYCLES(1), .DIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_wide(op_wide),
        .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_lo(alu_lo), .alu_hi(alu_hi),
        .done(done), .trap(trap)
    );

    // Behavioural alu; divide by zero returns all ones (quotient) and A (remainder).
    logic [63:0] prod;
    always_comb begin
        prod   = {32'd0, alu_a} * {32'd0, alu_b};
        alu_hi = 32'd0;
        case (alu_op)
            OP_INC:  alu_lo = alu_b + 32'd1;
            OP_ADD:  alu_lo = alu_a + alu_b;
            OP_SUB:  alu_lo = alu_a - alu_b;
            OP_MUL:  begin alu_lo = prod[31:0]; alu_hi = prod[63:32]; end
            OP_DIV:  alu_lo = (alu_b == 32'd0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            OP_REM:  alu_lo = (alu_b == 32'd0) ? alu_a : alu_a % alu_b;
            OP_AND:  alu_lo = alu_a & alu_b;
            OP_OR:   alu_lo = alu_a | alu_b;
            OP_XOR:  alu_lo = alu_a ^ alu_b;
            OP_NEG:  alu_lo = 32'd0 - alu_b;
            default: alu_lo = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Cycle 0 is the accept cycle; w0 is the first word popped (B), w1 the second (A).
    task automatic run_op(input logic [3:0] code, input logic wide,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int pstall, input int lstall, input int hstall,
                          input bit pulse);
        int ps, ls, hs, pidx;
        logic [31:0] cur;
        bit in_push;
        ps = pstall; ls = lstall; hs = hstall; pidx = 0; in_push = 0; cur = 0;
        n_pop = 0; n_push = 0; done_cyc = -1; last_pop_cyc = 0; first_push_cyc = 0;
        push0 = 0; push1 = 0; a_seen = 0; b_seen = 0; op_seen = 0;
        trap_seen = 0; push_unstable = 0;
        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_wide = wide;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            op_valid   = pulse && (k == 3);
            op_code    = pulse ? OP_XOR : code;
            pop_valid  = 1'b0;
            push_ready = 1'b0;
            if (pop_req) begin
                if (ps > 0) begin
                    ps--;
                end else begin
                    pop_valid = 1'b1;
                    pop_data  = (pidx == 0) ? w0 : w1;
                    pidx++; n_pop++; last_pop_cyc = k; ps = pstall;
                end
            end
            if (push_valid) begin
                if (n_push == 0 && !in_push) first_push_cyc = k;
                if (!in_push) begin
                    cur = push_data; in_push = 1;
                end else if (push_data !== cur) begin
                    push_unstable = 1;
                end
                if (n_push == 0 && ls > 0) begin
                    ls--;
                end else if (n_push != 0 && hs > 0) begin
                    hs--;
                end else begin
                    push_ready = 1'b1;
                    if (n_push == 0) push0 = push_data; else push1 = push_data;
                    n_push++; in_push = 0;
                    op_seen = alu_op; a_seen = alu_a; b_seen = alu_b;
                end
            end
            if (done) begin
                done_cyc = k; trap_seen = trap;
                break;
            end
        end
        pop_valid = 1'b0; push_ready = 1'b1; op_valid = 1'b0;
        if (done_cyc < 0) chk("timeout", 32'd0, 32'd1);
        @(negedge clk);
        ready_after = op_ready; popreq_after = pop_req;
    endtask

    int n_bad;

    initial begin
        rst_n = 1'b0; op_valid = 0; op_code = 0; op_wide = 0;
        pop_valid = 0; pop_data = 0; push_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
        chk("rst_pop_req", {31'd0, pop_req}, 32'd0);
        chk("rst_push_valid", {31'd0, push_valid}, 32'd0);
        chk("rst_done_trap", {30'd0, done, trap}, 32'd0);
        chk("rst_alu_ab", alu_a | alu_b, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 0xFF + 0xFF, no stalls
        run_op(OP_ADD, 1'b0, 32'hFF, 32'hFF, 0, 0, 0, 0);
        chk("add_push", push0, 32'h0000_01FE);
        chk("add_npush", n_push, 32'd1);
        chk("add_npop", n_pop, 32'd2);
        chk("add_alu_op", {28'd0, op_seen}, 32'h1);
        chk("add_done_cyc", done_cyc, 32'd5);
        chk("add_ready_after", {31'd0, ready_after}, 32'd1);

        // DIV 0xFF / 0xFF: four-cycle execute window
        run_op(OP_DIV, 1'b0, 32'hFF, 32'hFF, 0, 0, 0, 0);
        chk("div_push", push0, 32'h0000_0001);
        chk("div_exec_len", first_push_cyc - last_pop_cyc - 1, 32'd4);
        chk("div_done_cyc", done_cyc, 32'd8);

        // AND with three stall cycles before each pop, spurious op_valid mid-op
        run_op(OP_AND, 1'b0, 32'hFF, 32'hFF, 3, 0, 0, 1);
        chk("and_push", push0, 32'h0000_00FF);
        chk("and_done_cyc", done_cyc, 32'd11);
        chk("and_npop", n_pop, 32'd2);
        chk("and_no_restart", {31'd0, popreq_after}, 32'd0);

        // SUB checks operand order: B=3 popped first, A=10 second, A-B
        run_op(OP_SUB, 1'b0, 32'd3, 32'd10, 0, 0, 0, 0);
        chk("sub_push", push0, 32'd7);
        chk("sub_alu_a", a_seen, 32'd10);

        // MUL wide with hi push stalled two cycles
        run_op(OP_MUL, 1'b1, 32'h0001_0000, 32'h0001_0000, 0, 0, 2, 0);
        chk("mul_npush", n_push, 32'd2);
        chk("mul_push_lo", push0, 32'h0000_0000);
        chk("mul_push_hi", push1, 32'h0000_0001);
        chk("mul_stable", {31'd0, push_unstable}, 32'd0);
        chk("mul_done_cyc", done_cyc, 32'd8);

        // INC: single pop, A forced to zero
        run_op(OP_INC, 1'b0, 32'h7, 32'hDEAD_BEEF, 0, 0, 0, 0);
        chk("inc_npop", n_pop, 32'd1);
        chk("inc_alu_a", a_seen, 32'd0);
        chk("inc_alu_b", b_seen, 32'd7);
        chk("inc_push", push0, 32'd8);
        chk("inc_done_cyc", done_cyc, 32'd4);

        // DIV by zero: B=0 popped first, A=10
        run_op(OP_DIV, 1'b0, 32'd0, 32'd10, 0, 0, 0, 0);
`ifdef ALU_DIV_ZERO_TRAP_EN
        chk("dz_trap", {31'd0, trap_seen}, 32'd1);
        chk("dz_npush", n_push, 32'd0);
        chk("dz_done_cyc", done_cyc, 32'd3);
`else
        chk("dz_trap", {31'd0, trap_seen}, 32'd0);
        chk("dz_push", push0, 32'hFFFF_FFFF);
        chk("dz_done_cyc", done_cyc, 32'd8);
`endif

        // Reset asserted during EXEC aborts the operation
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIV; op_wide = 1'b0; pop_valid = 1'b1; pop_data = 32'h55;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_pre_b", alu_b, 32'h55);
        rst_n = 1'b0; pop_valid = 1'b0;
        #1;
        chk("abort_op_ready", {31'd0, op_ready}, 32'd1);
        chk("abort_alu_b", alu_b, 32'd0);
        chk("abort_alu_op", {28'd0, alu_op}, 32'd0);
        chk("abort_push_valid", {31'd0, push_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (push_valid || done || !op_ready) n_bad++;
        end
        chk("abort_quiet", n_bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
